demux_fifo: RTL and testbench
=============================

# demux_fifo

Registered 1:2 demultiplexer with a per-lane FIFO. It is the inverse of the team's 2-bit 2:1 mux stage: a single `data_in` stream is steered by `selector` into one of two lanes. Each lane buffers up to `DEPTH` words until the downstream consumer pops them. It sits on the receiving side of the two-lane link and gives each consumer its own valid/pop handshake, full flag and occupancy count.

## Interface
- `BW`, default 2: data width of every data port.
- `DEPTH`, default 4: entries per lane FIFO; power of two, ≥ 2.
- `CW`, default `$clog2(DEPTH)+1`: width of the occupancy counts; derived, not overridden.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset_L`  input  1  reset, asynchronous, active-low.
- `valid_in`  input  1  push request for the word on `data_in`.
- `selector`  input  1  target lane (0 → lane 0, 1 → lane 1); sampled with `valid_in`.
- `data_in`  input  BW  word to push.
- `pop0` / `pop1`  input  1  consumer of lane 0 / lane 1 takes the head word.
- `data_out0` / `data_out1`  output  BW  head word of lane 0 / lane 1; 0 when that lane is empty.
- `valid_out0` / `valid_out1`  output  1  lane non-empty.
- `full0` / `full1`  output  1  lane holds `DEPTH` words.
- `count0` / `count1`  output  CW  lane occupancy, 0..DEPTH.
- `err`  output  1  sticky protocol-error flag.

## Operation
- **Per-lane state:** `DEPTH`×`BW` storage, write pointer, read pointer (each `log2(DEPTH)` bits, wrapping modulo `DEPTH`), and a count.
- **Push:** accepted on a rising edge when `valid_in`=1 and the selected lane's current `fullN`=0.
  - The word is written at the write pointer; the write pointer increments.
  - The other lane is untouched.
- **Pop:** performed on lane N when `popN`=1 and `valid_outN`=1. The read pointer increments.
- **Count update:** `countN` +1 on push only, −1 on pop only, unchanged on push+pop in the same edge.
- **Full lane:** a push to a lane whose `fullN`=1 before the edge is dropped, even if `popN` pops that lane on the same edge. That lane's pop still occurs.
- **Both lanes:** simultaneous `pop0`, `pop1` and a push are all legal in one cycle.
- **Head read:** `data_outN` = storage[rd_ptrN] when `countN`≠0, else 0. This is a show-ahead read, combinational from registered state.
- **Flags:** `valid_outN` = (`countN`≠0); `fullN` = (`countN`==`DEPTH`).
- **Error:** `err` is set on any edge with a dropped push or a `popN` while `valid_outN`=0. It stays set until reset.
  - An illegal pop changes no state.
  - `valid_in`=0 makes `selector` and `data_in` don't-care.

## Timing
- **Reset:** `reset_L`=0 immediately, with no clock required:
  - pointers and counts go to 0;
  - storage is cleared to 0;
  - every output goes to 0: `data_out*`=0, `valid_out*`=0, `full*`=0, `count*`=0, `err`=0.
- **Reset release:** the first push can be accepted on the first rising edge with `reset_L`=1.
- **Reset mid-operation:** all buffered words are discarded. No partial push or pop completes on an edge coincident with `reset_L`=0.
- **Push latency:** a push accepted at edge k gives `valid_outN`=1 and the word on `data_outN` after edge k (cycle k+1). That is 1 cycle from push to visible.
- **Pop latency:** a pop at edge k shows the next head (or 0/invalid) after edge k.
- **Full timing:** `fullN` rises after the edge that stores word `DEPTH` and falls after the first pop.
- **Error timing:** `err` rises after the offending edge.
- **Wrap-around:** pointers roll from `DEPTH`−1 to 0 with no bubble. FIFO order is preserved across wrap.

## Test plan
- **Reset:** hold `reset_L`=0, toggle inputs → all outputs 0. Release, push 2'b10 to lane 1 → next cycle `valid_out1`=1, `data_out1`=2'b10, `count1`=1; lane 0 stays empty.
- **Fill and overflow:** push 0,1,2,3 to lane 0 → `full0`=1, `count0`=4. A 5th push of 2'b01 is dropped and `err`=1. Pops return 0,1,2,3 in order, then `valid_out0`=0 and `data_out0`=0.
- **Wrap-around:** for lane 1, alternate push/pop of 10 words (3,2,1,0,…) with ≥2 in flight → order preserved across pointer wrap, `count1` never exceeds 2, `err` stays 0.
- **Simultaneous events:**
  - Lane 0 full; push to lane 0 with `pop0`=1 in the same cycle → push dropped, `err`=1, `count0`=3.
  - Lane 0 at count 2; push plus pop on lane 0 → `count0` stays 2.
  - `pop0`, `pop1` and a push to lane 1 in one cycle → all three take effect.
- **Underflow:** `pop1`=1 on an empty lane 1 → no state change, `err`=1, and `err` stays 1 until `reset_L` pulses low.
- **Async reset mid-stream:** assert `reset_L`=0 between clock edges with 3 words buffered → outputs go to 0 before the next edge. After release the lanes are empty and the first push behaves as in scenario 1.

Source files
------------

// File: rtl/demux_fifo.sv
// demux_fifo: registered 1:2 demultiplexer feeding two independent FIFO lanes.
// Each lane has its own show-ahead head word, valid/pop handshake, full flag and
// occupancy count. The err flag is sticky and records every dropped push and
// every pop of an empty lane.
module demux_fifo #(
  parameter  int unsigned BW    = 2,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          valid_in,
  input  logic          selector,
  input  logic [BW-1:0] data_in,
  input  logic          pop0,
  input  logic          pop1,
  output logic [BW-1:0] data_out0,
  output logic [BW-1:0] data_out1,
  output logic          valid_out0,
  output logic          valid_out1,
  output logic          full0,
  output logic          full1,
  output logic [CW-1:0] count0,
  output logic [CW-1:0] count1,
  output logic          err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned NL = 2;

  // Per-lane storage and bookkeeping, indexed by lane number.
  logic [BW-1:0] mem    [NL][DEPTH];
  logic [PW-1:0] wr_ptr [NL];
  logic [PW-1:0] rd_ptr [NL];
  logic [CW-1:0] cnt    [NL];
  logic          err_q;

  logic [NL-1:0] push_req;
  logic [NL-1:0] push_ok;
  logic [NL-1:0] pop_req;
  logic [NL-1:0] pop_ok;
  logic [NL-1:0] lane_valid;
  logic [NL-1:0] lane_full;
  logic          drop;
  logic          underflow;

  // Lane status flags derived from the registered occupancy counts.
  always_comb begin
    lane_valid = '0;
    lane_full  = '0;
    for (int l = 0; l < NL; l++) begin
      lane_valid[l] = (cnt[l] != '0);
      lane_full[l]  = (cnt[l] == CW'(DEPTH));
    end
  end

  // Steer the incoming push and qualify pushes/pops against the pre-edge state.
  always_comb begin
    push_req    = '0;
    pop_req     = '0;
    push_req[0] = valid_in & ~selector;
    push_req[1] = valid_in &  selector;
    pop_req[0]  = pop0;
    pop_req[1]  = pop1;
    // A push into a full lane is dropped even if that lane pops on the same edge.
    push_ok     = push_req & ~lane_full;
    pop_ok      = pop_req  &  lane_valid;
    drop        = |(push_req & lane_full);
    underflow   = |(pop_req & ~lane_valid);
  end

  // Storage writes; storage is cleared on reset so the head reads 0 afterwards.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < NL; l++) begin
        for (int e = 0; e < DEPTH; e++) begin
          mem[l][e] <= '0;
        end
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (push_ok[l]) begin
          mem[l][wr_ptr[l]] <= data_in;
        end
      end
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < NL; l++) begin
        wr_ptr[l] <= '0;
        rd_ptr[l] <= '0;
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (push_ok[l]) begin
          wr_ptr[l] <= wr_ptr[l] + PW'(1);
        end
        if (pop_ok[l]) begin
          rd_ptr[l] <= rd_ptr[l] + PW'(1);
        end
      end
    end
  end

  // Occupancy counts: a push and a pop on the same edge cancel out.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int l = 0; l < NL; l++) begin
        cnt[l] <= '0;
      end
    end else begin
      for (int l = 0; l < NL; l++) begin
        if (push_ok[l] && !pop_ok[l]) begin
          cnt[l] <= cnt[l] + CW'(1);
        end else if (!push_ok[l] && pop_ok[l]) begin
          cnt[l] <= cnt[l] - CW'(1);
        end
      end
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_q <= 1'b0;
    end else if (drop || underflow) begin
      err_q <= 1'b1;
    end
  end

  // Show-ahead head words and status outputs, straight from registered state.
  always_comb begin
    data_out0  = lane_valid[0] ? mem[0][rd_ptr[0]] : '0;
    data_out1  = lane_valid[1] ? mem[1][rd_ptr[1]] : '0;
    valid_out0 = lane_valid[0];
    valid_out1 = lane_valid[1];
    full0      = lane_full[0];
    full1      = lane_full[1];
    count0     = cnt[0];
    count1     = cnt[1];
    err        = err_q;
  end

endmodule

// File: tb/tb_demux_fifo.sv
// tb_demux_fifo: directed stimulus for demux_fifo, checked every cycle against a
// queue-based model of the two lanes, plus hand-computed literal checkpoints.
module tb_demux_fifo;

  localparam int unsigned BW    = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          reset_L;
  logic          valid_in;
  logic          selector;
  logic [BW-1:0] data_in;
  logic          pop0;
  logic          pop1;
  logic [BW-1:0] data_out0;
  logic [BW-1:0] data_out1;
  logic          valid_out0;
  logic          valid_out1;
  logic          full0;
  logic          full1;
  logic [CW-1:0] count0;
  logic [CW-1:0] count1;
  logic          err;

  int vectors     = 0;
  int miscompares = 0;

  demux_fifo #(.BW(BW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .valid_in   (valid_in),
    .selector   (selector),
    .data_in    (data_in),
    .pop0       (pop0),
    .pop1       (pop1),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .valid_out0 (valid_out0),
    .valid_out1 (valid_out1),
    .full0      (full0),
    .full1      (full1),
    .count0     (count0),
    .count1     (count1),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: one queue per lane plus a sticky error bit.
  logic [BW-1:0] q0 [$];
  logic [BW-1:0] q1 [$];
  bit            err_m = 1'b0;
  int            s0;
  int            s1;

  always @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      q0.delete();
      q1.delete();
      err_m = 1'b0;
    end else begin
      s0 = q0.size();
      s1 = q1.size();
      if ((pop0 && s0 == 0) || (pop1 && s1 == 0)) err_m = 1'b1;
      if (pop0 && s0 != 0) void'(q0.pop_front());
      if (pop1 && s1 != 0) void'(q1.pop_front());
      if (valid_in) begin
        if (!selector) begin
          if (s0 == DEPTH) err_m = 1'b1;
          else q0.push_back(data_in);
        end else begin
          if (s1 == DEPTH) err_m = 1'b1;
          else q1.push_back(data_in);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    chk("data_out0",  int'(data_out0),  q0.size() != 0 ? int'(q0[0]) : 0);
    chk("data_out1",  int'(data_out1),  q1.size() != 0 ? int'(q1[0]) : 0);
    chk("valid_out0", int'(valid_out0), int'(q0.size() != 0));
    chk("valid_out1", int'(valid_out1), int'(q1.size() != 0));
    chk("full0",      int'(full0),      int'(q0.size() == DEPTH));
    chk("full1",      int'(full1),      int'(q1.size() == DEPTH));
    chk("count0",     int'(count0),     q0.size());
    chk("count1",     int'(count1),     q1.size());
    chk("err",        int'(err),        int'(err_m));
  end

  // Apply one cycle of inputs; returns at the following falling edge.
  task automatic step(input bit v, input bit s, input logic [BW-1:0] d,
                      input bit p0, input bit p1);
    valid_in = v;
    selector = s;
    data_in  = d;
    pop0     = p0;
    pop1     = p1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  // Reset pulse placed away from both clock edges.
  task automatic pulse_reset();
    #2 reset_L = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_L = 1'b1;
  endtask

  logic [BW-1:0] wrap_words [10] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3,
                                     2'd2, 2'd1, 2'd0, 2'd3, 2'd2};

  initial begin
    reset_L  = 1'b0;
    valid_in = 1'b0;
    selector = 1'b0;
    data_in  = '0;
    pop0     = 1'b0;
    pop1     = 1'b0;
    @(negedge clk);

    // Reset held: inputs toggle, outputs stay 0.
    step(1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    step(1'b1, 1'b1, 2'd2, 1'b0, 1'b1);
    step(1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
    chk("rst_valid0", int'(valid_out0), 0);
    chk("rst_count1", int'(count1), 0);
    chk("rst_err", int'(err), 0);

    // Release and push 2'b10 to lane 1.
    #2 reset_L = 1'b1;
    step(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    chk("s1_valid1", int'(valid_out1), 1);
    chk("s1_data1", int'(data_out1), 2);
    chk("s1_count1", int'(count1), 1);
    chk("s1_valid0", int'(valid_out0), 0);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);

    // Fill lane 0 and overflow it.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'(i), 1'b0, 1'b0);
    chk("fill_full0", int'(full0), 1);
    chk("fill_count0", int'(count0), 4);
    chk("fill_head0", int'(data_out0), 0);
    step(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    chk("ovf_err", int'(err), 1);
    chk("ovf_count0", int'(count0), 4);
    step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("pop_head0", int'(data_out0), 1);
    chk("pop_full0", int'(full0), 0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
    chk("drain_valid0", int'(valid_out0), 0);
    chk("drain_data0", int'(data_out0), 0);
    pulse_reset();

    // Lane 1 streaming across pointer wrap with two words in flight.
    step(1'b1, 1'b1, wrap_words[0], 1'b0, 1'b0);
    step(1'b1, 1'b1, wrap_words[1], 1'b0, 1'b0);
    for (int i = 2; i < 10; i++) step(1'b1, 1'b1, wrap_words[i], 1'b0, 1'b1);
    chk("wrap_head1", int'(data_out1), 3);
    chk("wrap_count1", int'(count1), 2);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("wrap_last1", int'(data_out1), 2);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("wrap_err", int'(err), 0);

    // Push to a full lane 0 with a simultaneous pop.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 2'(3 - i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
    chk("fullpp_err", int'(err), 1);
    chk("fullpp_count0", int'(count0), 3);
    chk("fullpp_head0", int'(data_out0), 2);
    pulse_reset();

    // Push plus pop at count 2, then pop0 + pop1 + push to lane 1.
    step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd3, 1'b1, 1'b0);
    chk("pp_count0", int'(count0), 2);
    chk("pp_head0", int'(data_out0), 2);
    step(1'b1, 1'b1, 2'd1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd3, 1'b1, 1'b1);
    chk("tri_head0", int'(data_out0), 3);
    chk("tri_count0", int'(count0), 1);
    chk("tri_head1", int'(data_out1), 3);
    chk("tri_count1", int'(count1), 1);
    chk("tri_err", int'(err), 0);

    // Underflow on lane 1, error stays sticky until reset.
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
    chk("uf_err", int'(err), 1);
    chk("uf_count1", int'(count1), 0);
    chk("uf_count0", int'(count0), 1);
    idle();
    idle();
    chk("uf_sticky", int'(err), 1);
    pulse_reset();
    chk("uf_cleared", int'(err), 0);

    // Asynchronous reset with three words buffered.
    step(1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    step(1'b1, 1'b1, 2'd3, 1'b0, 1'b0);
    valid_in = 1'b0;
    #2 reset_L = 1'b0;
    #1;
    chk("ar_valid0", int'(valid_out0), 0);
    chk("ar_count0", int'(count0), 0);
    chk("ar_data1", int'(data_out1), 0);
    chk("ar_valid1", int'(valid_out1), 0);
    @(negedge clk);
    #2 reset_L = 1'b1;
    step(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    chk("ar_push_data1", int'(data_out1), 2);
    chk("ar_push_count1", int'(count1), 1);
    chk("ar_lane0_empty", int'(count0), 0);
    idle();

    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
